// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory read, one held instruction for decode.
// One instruction per two cycles at best; a stall parks the held instruction; redirects squash in-flight reads.
module fetch_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_valid,
    output logic [7:0]  o_squash_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // Addresses are word aligned, so only bits [31:2] are stored.
    logic [29:0] fetch_addr_q, fetch_addr_d;
    logic [29:0] pend_q, pend_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [7:0]  squash_q, squash_d;
    logic        mem_req_q, inst_valid_q;
    logic [7:0]  squash_sat;
    logic [1:0]  unused_pc_lsbs;

    assign unused_pc_lsbs = i_redirect_pc[1:0];
    assign squash_sat     = (squash_q == 8'hFF) ? squash_q : squash_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pend_d       = pend_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        squash_d     = squash_q;
        case (state_q)
            FETCH: begin
                if (i_mem_ack && i_redirect) begin
                    fetch_addr_d = i_redirect_pc[31:2];
                    squash_d     = squash_sat;
                end else if (i_mem_ack) begin
                    inst_d       = i_mem_rdata;
                    inst_pc_d    = {fetch_addr_q, 2'b00};
                    fetch_addr_d = fetch_addr_q + 30'd1;
                    state_d      = HOLD;
                end else if (i_redirect) begin
                    pend_d  = i_redirect_pc[31:2];
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                // Acks here cannot belong to us: no request is outstanding.
                if (i_redirect) begin
                    fetch_addr_d = i_redirect_pc[31:2];
                    state_d      = FETCH;
                end else if (!i_stall) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (i_mem_ack) begin
                    squash_d     = squash_sat;
                    fetch_addr_d = i_redirect ? i_redirect_pc[31:2] : pend_q;
                    state_d      = FETCH;
                end else if (i_redirect) begin
                    pend_d = i_redirect_pc[31:2];
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= FETCH;
            fetch_addr_q <= RESET_ADDR[31:2];
            pend_q       <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            squash_q     <= '0;
            mem_req_q    <= 1'b1;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pend_q       <= pend_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            squash_q     <= squash_d;
            mem_req_q    <= (state_d != HOLD);
            inst_valid_q <= (state_d == HOLD);
        end
    end

    assign o_mem_req    = mem_req_q;
    assign o_mem_addr   = {fetch_addr_q, 2'b00};
    assign o_inst       = inst_q;
    assign o_inst_pc    = inst_pc_q;
    assign o_inst_valid = inst_valid_q;
    assign o_squash_cnt = squash_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (reset address 0 and 0xFFFFFFFC) share directed stimulus
// and are compared every cycle against a request/poison model, plus literal checkpoints.
module tb_fetch_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        i_stall = 1'b0;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;

    logic        a_mem_req, b_mem_req, a_inst_valid, b_inst_valid;
    logic [31:0] a_mem_addr, b_mem_addr, a_inst, b_inst, a_inst_pc, b_inst_pc;
    logic [7:0]  a_squash_cnt, b_squash_cnt;

    fetch_sequencer #(.RESET_ADDR(32'h0000_0000)) u_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .i_stall(i_stall), .o_mem_req(a_mem_req), .o_mem_addr(a_mem_addr), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata), .o_inst(a_inst), .o_inst_pc(a_inst_pc),
        .o_inst_valid(a_inst_valid), .o_squash_cnt(a_squash_cnt)
    );

    fetch_sequencer #(.RESET_ADDR(32'hFFFF_FFFC)) u_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .i_stall(i_stall), .o_mem_req(b_mem_req), .o_mem_addr(b_mem_addr), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata), .o_inst(b_inst), .o_inst_pc(b_inst_pc),
        .o_inst_valid(b_inst_valid), .o_squash_cnt(b_squash_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // hold: an instruction is parked for decode; otherwise a read of addr is in flight.
    // poison: the in-flight read was overtaken by a redirect and must be thrown away.
    typedef struct {
        logic        hold;
        logic        poison;
        logic [31:0] addr;
        logic [31:0] target;
        logic [31:0] inst;
        logic [31:0] pc;
        int          sq;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(input mdl_t s, input logic [31:0] rst_addr);
        mdl_t n = s;
        if (i_rst) begin
            n.hold = 0; n.poison = 0; n.addr = rst_addr & ~32'h3; n.target = 0;
            n.inst = 0; n.pc = 0; n.sq = 0;
        end else if (s.hold) begin
            if (i_redirect) begin
                n.hold = 0;
                n.addr = i_redirect_pc & ~32'h3;
            end else if (!i_stall) begin
                n.hold = 0;
            end
        end else if (i_mem_ack) begin
            if (s.poison || i_redirect) begin
                n.sq     = (s.sq < 255) ? s.sq + 1 : 255;
                n.addr   = (i_redirect ? i_redirect_pc : s.target) & ~32'h3;
                n.poison = 0;
            end else begin
                n.hold = 1; n.inst = i_mem_rdata; n.pc = s.addr; n.addr = s.addr + 32'd4;
            end
        end else if (i_redirect) begin
            n.poison = 1;
            n.target = i_redirect_pc;
        end
        return n;
    endfunction

    always @(posedge i_clk) begin
        ma = step(ma, 32'h0000_0000);
        mb = step(mb, 32'hFFFF_FFFC);
    end

    task automatic chk_dut(input string t, input mdl_t m, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] inst, input logic [31:0] pc,
                           input logic [7:0] sq);
        cmp({t, ".mem_req"}, {31'd0, req}, {31'd0, ~m.hold});
        cmp({t, ".inst_valid"}, {31'd0, vld}, {31'd0, m.hold});
        cmp({t, ".squash_cnt"}, {24'd0, sq}, 32'(m.sq));
        if (!m.hold) cmp({t, ".mem_addr"}, addr, m.addr);
        if (m.hold) begin
            cmp({t, ".inst"}, inst, m.inst);
            cmp({t, ".inst_pc"}, pc, m.pc);
        end
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk_dut("A", ma, a_mem_req, a_mem_addr, a_inst_valid, a_inst, a_inst_pc, a_squash_cnt);
            chk_dut("B", mb, b_mem_req, b_mem_addr, b_inst_valid, b_inst, b_inst_pc, b_squash_cnt);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        cmp("rst.req", {31'd0, a_mem_req}, 32'd1);
        cmp("rst.addr", a_mem_addr, 32'h0);
        cmp("rst.valid", {31'd0, a_inst_valid}, 32'd0);
        cmp("rst.squash", {24'd0, a_squash_cnt}, 32'd0);
        cmp("rstB.addr", b_mem_addr, 32'hFFFF_FFFC);

        // Back-to-back single-cycle acks: one instruction every other cycle.
        i_rst = 1'b0;
        i_mem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_mem_rdata = a_mem_addr ^ 32'hA5A5_A5A5;
            tick();
            if (i % 2 == 0) begin
                cmp("stream.valid", {31'd0, a_inst_valid}, 32'd1);
                cmp("stream.pc", a_inst_pc, 32'(2 * i));
                cmp("stream.inst", a_inst, 32'(2 * i) ^ 32'hA5A5_A5A5);
            end else begin
                cmp("stream.gap", {31'd0, a_inst_valid}, 32'd0);
            end
            if (i == 0) cmp("wrapB.pc", b_inst_pc, 32'hFFFF_FFFC);
            if (i == 1) cmp("wrapB.addr", b_mem_addr, 32'h0);
        end

        // Park pc 8 in HOLD and stall for three cycles.
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_mem_rdata = a_mem_addr ^ 32'hA5A5_A5A5;
            tick();
        end
        cmp("hold.pc", a_inst_pc, 32'h8);
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("stall.valid", {31'd0, a_inst_valid}, 32'd1);
            cmp("stall.pc", a_inst_pc, 32'h8);
            cmp("stall.req", {31'd0, a_mem_req}, 32'd0);
        end
        i_stall = 1'b0;
        tick();
        cmp("release.addr", a_mem_addr, 32'hC);

        // Two redirects while the read of 0x10 is slow; latest target wins.
        i_mem_rdata = 32'hC ^ 32'hA5A5_A5A5;
        tick();
        i_mem_ack = 1'b0;
        tick();
        cmp("drain.start", a_mem_addr, 32'h10);
        i_redirect = 1'b1; i_redirect_pc = 32'h200;
        tick();
        cmp("drain.hold1", a_mem_addr, 32'h10);
        i_redirect_pc = 32'h300;
        tick();
        cmp("drain.hold2", a_mem_addr, 32'h10);
        i_redirect = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h10 ^ 32'hA5A5_A5A5;
        tick();
        cmp("drain.addr", a_mem_addr, 32'h300);
        cmp("drain.squash", {24'd0, a_squash_cnt}, 32'd1);
        cmp("drain.valid", {31'd0, a_inst_valid}, 32'd0);

        // Redirect coincident with ack in FETCH.
        i_redirect = 1'b1; i_redirect_pc = 32'h40;
        tick();
        cmp("coin.valid", {31'd0, a_inst_valid}, 32'd0);
        cmp("coin.addr", a_mem_addr, 32'h40);
        i_redirect = 1'b0; i_mem_rdata = 32'h40 ^ 32'hA5A5_A5A5;
        tick();
        cmp("coin.next_pc", a_inst_pc, 32'h40);

        // Redirect beats stall in HOLD; unaligned target is word aligned.
        i_stall = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h123;
        tick();
        cmp("hold_redir.addr", a_mem_addr, 32'h120);
        i_stall = 1'b0; i_mem_ack = 1'b0; i_redirect_pc = 32'h80;
        tick();
        i_mem_ack = 1'b1; i_redirect_pc = 32'h90;
        tick();
        cmp("drain_redir.addr", a_mem_addr, 32'h90);
        cmp("drain_redir.squash", {24'd0, a_squash_cnt}, 32'd3);
        i_redirect = 1'b0; i_mem_ack = 1'b0;
        tick();

        // Squash counter saturation, then reset mid-stream.
        i_redirect = 1'b1; i_mem_ack = 1'b1;
        for (int i = 0; i < 300; i++) begin
            i_redirect_pc = 32'(i * 4);
            tick();
        end
        cmp("sat.squash", {24'd0, a_squash_cnt}, 32'hFF);
        i_rst = 1'b1;
        tick();
        cmp("midrst.squash", {24'd0, a_squash_cnt}, 32'd0);
        cmp("midrst.addr", a_mem_addr, 32'h0);
        cmp("midrstB.addr", b_mem_addr, 32'hFFFF_FFFC);
        i_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            i_redirect_pc = 32'h1000 + 32'(i * 4);
            tick();
        end
        cmp("post.squash", {24'd0, a_squash_cnt}, 32'd20);
        i_redirect = 1'b0; i_mem_ack = 1'b0;
        tick();
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
